haz_unit_sb: RTL
================

# haz_unit_sb

Parametrised hazard unit for the five-stage core. It keeps the existing operand forwarding and load-use stall, and adds four things: a per-register scoreboard for a variable-latency long-op unit (mul/div), bounded outstanding long ops, data-memory wait freezing, and arbitration of the shared writeback port. It sits between the pipeline registers, the long-op unit and the register file, and drives every stall, flush and forward select in the core.

## Interface
- REG_AW, 5: register address width; NREGS = 2**REG_AW.
- LU_MAX, 2: maximum outstanding long ops (1..4).
- CNT_W, 32: stall-cycle counter width.
- clk  in  1  core clock.
- rst_n  in  1  synchronous active-low reset, sampled on rising clk.
- rs1_d, rs2_d, rd_d  in  REG_AW  decode-stage register fields.
- rs1_e, rs2_e, rd_e  in  REG_AW  execute-stage register fields.
- rd_m, rd_w  in  REG_AW  memory/writeback destinations.
- regwrite_m, regwrite_w  in  1  pipeline write enables.
- resultsrc_e  in  2  execute result select; bit 0 = load.
- pcsrc_e  in  1  taken branch/jump resolved in E.
- lu_req_e  in  1  instruction in E is a long op.
- lu_wb_valid  in  1  long unit presents a result.
- lu_wb_rd  in  REG_AW  destination of that result.
- dmem_stall  in  1  data memory not ready this cycle.
- lu_issue  out  1  long op in E accepted this cycle.
- lu_wb_ready  out  1  long-unit writeback granted.
- stall_f, stall_d, stall_e, stall_m  out  1  hold the stage register.
- flush_d, flush_e, flush_m, flush_w  out  1  bubble into the stage register.
- forwarda_e, forwardb_e  out  2  ALU operand select.
- sb_pending  out  NREGS  scoreboard bits.
- stall_cycles  out  CNT_W  count of cycles with stall_f=1.

## Operation
- **Forwarding (per operand, rs_e != 0):**
  - MEM if rs==rd_m and regwrite_m.
  - else WB if rs==rd_w and regwrite_w.
  - else NONE.
- **Use stall (`usestall`):** (resultsrc_e[0] or lu_req_e) and rd_e != 0 and (rs1_d==rd_e or rs2_d==rd_e).
- **Scoreboard stall (`sbstall`):** sb_pending[rs1_d], sb_pending[rs2_d] or sb_pending[rd_d] set, with index 0 excluded. This covers RAW and WAW.
- **Lu-full stall (`lufull`):** lu_req_e and outstanding==LU_MAX.
- **Priority, highest first:**
  - dmem_stall: stall_f/d/e/m=1, flush_w=1, all other flushes 0, lu_issue=0.
  - lufull: stall_f/d/e=1, flush_m=1; pcsrc_e is ignored.
  - usestall or sbstall: stall_f/d=1, flush_e=1; if pcsrc_e is also set, add flush_d=1.
  - pcsrc_e: flush_d=1, flush_e=1.
- lu_issue = lu_req_e and not dmem_stall and outstanding < LU_MAX.
- **Scoreboard updates:**
  - Set bit rd_e on lu_issue (rd_e != 0).
  - Clear bit lu_wb_rd on lu_wb_valid and lu_wb_ready.
  - If set and clear hit the same index in the same cycle, set wins.
  - Bit 0 is constant 0.
- **Outstanding counter:** +1 on issue, -1 on writeback handshake, unchanged when both occur. Never exceeds LU_MAX and never goes below 0.
- **Writeback arbitration:** lu_wb_ready = not regwrite_w (the pipeline has priority). The long unit holds valid and rd until ready.
- **Stall counter:** stall_cycles increments each cycle stall_f=1 and saturates at all-ones.

## Timing
- Forward, stall, flush, lu_issue and lu_wb_ready are combinational from the same-cycle inputs and state.
- sb_pending, the outstanding counter and stall_cycles update on the rising clk edge.
- A scoreboard clear releases the decode stall in the following cycle. The register file writes on the opposite edge, so no long-op forwarding path exists.
- **Reset** (rst_n=0 at an edge): sb_pending=0, outstanding=0, stall_cycles=0.
  - Long ops in flight are discarded; the long unit must be reset on the same rst_n.
  - Combinational outputs follow their inputs during reset.

## Structure
- Shared package haz_pkg holds:
  - enum fwd_sel_t: FWD_NONE=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - Localparam LU_CNT_W = $clog2(LU_MAX+1).
- One natural sub-module, haz_scoreboard: owns the pending bitmask, the outstanding counter and the set/clear rules, and exports pending bits plus a full flag.

## Test plan
- Forwarding: rs1_e=5, rd_m=5, regwrite_m=1, rd_w=5, regwrite_w=1 -> forwarda_e=10. Repeat with rs1_e=0 -> 00.
- Load-use: resultsrc_e=01, rd_e=7, rs2_d=7 -> stall_f/d=1, flush_e=1 for one cycle. With pcsrc_e=1 in the same cycle, flush_d=1 as well.
- Scoreboard:
  - Issue a long op to x9 -> sb_pending[9]=1 next cycle.
  - Decode reading x9 stalls until lu_wb_valid with rd=9 is accepted, then proceeds one cycle later.
  - rd_d=9 (WAW) also stalls.
- Capacity (LU_MAX=2): two issues with no writebacks; a third lu_req_e -> lufull stall, flush_m=1, lu_issue=0 until a handshake. Issue and handshake in the same cycle -> count unchanged.
- Writeback conflict: lu_wb_valid=1 with regwrite_w=1 -> lu_wb_ready=0 and the bit stays set. The next cycle with regwrite_w=0 -> cleared.
- Memory wait and reset:
  - dmem_stall for 3 cycles -> all stages held, flush_w=1, stall_cycles +3.
  - rst_n low mid-operation -> pending, outstanding and counter zero.

Source files
------------

// File: rtl/haz_pkg.sv
// haz_pkg: shared types and sizing for the hazard unit and its scoreboard
package haz_pkg;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_WB   = 2'b01,
        FWD_MEM  = 2'b10
    } fwd_sel_t;

    // The long-op counter is sized for the largest supported LU_MAX so that one
    // width serves every legal configuration (LU_MAX is 1..4).
    localparam int LU_MAX_CAP = 4;
    localparam int LU_CNT_W   = $clog2(LU_MAX_CAP + 1);

    // Operand bypass choice: the newest producer (MEM) wins over WB; x0 never forwards.
    function automatic fwd_sel_t fwd_pick(
        input logic [7:0] rs,
        input logic [7:0] rd_m,
        input logic       regwrite_m,
        input logic [7:0] rd_w,
        input logic       regwrite_w
    );
        return (rs == '0)                       ? FWD_NONE :
               (regwrite_m && rs == rd_m)       ? FWD_MEM  :
               (regwrite_w && rs == rd_w)       ? FWD_WB   : FWD_NONE;
    endfunction

endpackage

// File: rtl/haz_scoreboard.sv
// haz_scoreboard: per-register pending bits and outstanding count for the long-op unit
module haz_scoreboard
    import haz_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int LU_MAX = 2,
    localparam int NREGS = 2 ** REG_AW
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                set_en,
    input  logic [REG_AW-1:0]   set_rd,
    input  logic                clr_en,
    input  logic [REG_AW-1:0]   clr_rd,
    output logic [NREGS-1:0]    pending,
    output logic [LU_CNT_W-1:0] outstanding,
    output logic                full
);

    logic [NREGS-1:0]    pending_nxt;
    logic [LU_CNT_W-1:0] cnt_nxt;
    logic                dec;

    // An empty counter never decrements, so a stray handshake cannot underflow it.
    assign dec  = clr_en && outstanding != '0;
    assign full = outstanding >= LU_CNT_W'(LU_MAX);

    // Clear first, then set, so a same-index set/clear leaves the bit set; x0 stays clear.
    always_comb begin
        pending_nxt = pending;
        if (clr_en)
            pending_nxt[clr_rd] = 1'b0;
        if (set_en && set_rd != '0)
            pending_nxt[set_rd] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    // Issue and handshake in one cycle cancel; issue is gated by full upstream.
    always_comb begin
        cnt_nxt = outstanding;
        if (set_en && !dec)
            cnt_nxt = outstanding + LU_CNT_W'(1);
        else if (!set_en && dec)
            cnt_nxt = outstanding - LU_CNT_W'(1);
    end

    // Scoreboard state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending     <= '0;
            outstanding <= '0;
        end else begin
            pending     <= pending_nxt;
            outstanding <= cnt_nxt;
        end
    end

endmodule

// File: rtl/haz_unit_sb.sv
// haz_unit_sb: forwarding, stalls, flushes, long-op scoreboard and writeback arbitration
module haz_unit_sb
    import haz_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int LU_MAX = 2,
    parameter int CNT_W  = 32,
    localparam int NREGS = 2 ** REG_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic [REG_AW-1:0] rd_d,
    input  logic [REG_AW-1:0] rs1_e,
    input  logic [REG_AW-1:0] rs2_e,
    input  logic [REG_AW-1:0] rd_e,
    input  logic [REG_AW-1:0] rd_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              regwrite_m,
    input  logic              regwrite_w,
    input  logic [1:0]        resultsrc_e,
    input  logic              pcsrc_e,
    input  logic              lu_req_e,
    input  logic              lu_wb_valid,
    input  logic [REG_AW-1:0] lu_wb_rd,
    input  logic              dmem_stall,
    output logic              lu_issue,
    output logic              lu_wb_ready,
    output logic              stall_f,
    output logic              stall_d,
    output logic              stall_e,
    output logic              stall_m,
    output logic              flush_d,
    output logic              flush_e,
    output logic              flush_m,
    output logic              flush_w,
    output logic [1:0]        forwarda_e,
    output logic [1:0]        forwardb_e,
    output logic [NREGS-1:0]  sb_pending,
    output logic [CNT_W-1:0]  stall_cycles
);

    logic [LU_CNT_W-1:0] outstanding;
    logic                lu_full;
    logic                usestall;
    logic                sbstall;
    logic                lufull;

    // The pipeline owns the shared write port; the long unit waits while it is busy.
    assign lu_wb_ready = !regwrite_w;
    assign lu_issue    = lu_req_e && !dmem_stall && !lu_full;

    haz_scoreboard #(
        .REG_AW(REG_AW),
        .LU_MAX(LU_MAX)
    ) u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .set_en     (lu_issue),
        .set_rd     (rd_e),
        .clr_en     (lu_wb_valid && lu_wb_ready),
        .clr_rd     (lu_wb_rd),
        .pending    (sb_pending),
        .outstanding(outstanding),
        .full       (lu_full)
    );

    // Bypass selects for both ALU operands.
    always_comb begin
        forwarda_e = fwd_pick(8'(rs1_e), 8'(rd_m), regwrite_m, 8'(rd_w), regwrite_w);
        forwardb_e = fwd_pick(8'(rs2_e), 8'(rd_m), regwrite_m, 8'(rd_w), regwrite_w);
    end

    // Hazard detection: E-stage producer not yet available, pending long-op register, long unit full.
    always_comb begin
        usestall = (resultsrc_e[0] || lu_req_e) && rd_e != '0 &&
                   (rs1_d == rd_e || rs2_d == rd_e);
        sbstall  = (rs1_d != '0 && sb_pending[rs1_d]) ||
                   (rs2_d != '0 && sb_pending[rs2_d]) ||
                   (rd_d  != '0 && sb_pending[rd_d]);
        lufull   = lu_req_e && lu_full;
    end

    // Prioritised stall/flush generation: memory wait, long-unit full, decode hazards, redirect.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_m = 1'b0;
        flush_w = 1'b0;
        if (dmem_stall) begin
            {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
            flush_w = 1'b1;
        end else if (lufull) begin
            {stall_f, stall_d, stall_e} = 3'b111;
            flush_m = 1'b1;
        end else if (usestall || sbstall) begin
            {stall_f, stall_d} = 2'b11;
            flush_e = 1'b1;
            flush_d = pcsrc_e;
        end else if (pcsrc_e) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    // Saturating count of fetch-stall cycles.
    always_ff @(posedge clk) begin
        if (!rst_n)
            stall_cycles <= '0;
        else if (stall_f && !(&stall_cycles))
            stall_cycles <= stall_cycles + CNT_W'(1);
    end

endmodule
